// File: rtl/led_seg_scan.sv
// led_seg_scan: display stage behind the CPU LED bus.
// Shows an 8-bit value on a 4-digit multiplexed 7-segment display.
// The value is shown either as 2-digit hex or as unsigned decimal
// (0..255) with leading zeros blanked.
// Binary-to-BCD conversion is a sequential double-dabble FSM that
// runs one iteration per clock.
//
// Ports:
//   clk   - system clock
//   Reset - synchronous, active-high; dominates all other inputs
//   Value - value to display (n bits; only n = 8 is supported)
//   Mode  - 0 = hex, 1 = unsigned decimal
//   Seg   - segments, active-low, bit order {g,f,e,d,c,b,a} (registered)
//   An    - digit enables, active-low, An[0] = rightmost (registered)
//   Busy  - high while a conversion is in flight (registered)
module led_seg_scan #(
  parameter int n       = 8,
  parameter int REFRESH = 50000
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [n-1:0] Value,
  input  logic         Mode,
  output logic [6:0]   Seg,
  output logic [3:0]   An,
  output logic         Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int         RW        = $clog2(REFRESH);
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is >= 5.
  function automatic logic [11:0] bcd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Build all four digit patterns from a finished conversion.
  function automatic logic [3:0][6:0] build_digits(input logic       mode,
                                                   input logic [7:0]  src,
                                                   input logic [11:0] bcd);
    logic [3:0][6:0] d;
    d = {4{SEG_BLANK}};
    if (mode) begin
      d[0] = seg_encode(bcd[3:0]);
      // Tens is a leading zero only when hundreds is also zero.
      if ((bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0)) begin
        d[1] = SEG_BLANK;
      end else begin
        d[1] = seg_encode(bcd[7:4]);
      end
      if (bcd[11:8] == 4'd0) begin
        d[2] = SEG_BLANK;
      end else begin
        d[2] = seg_encode(bcd[11:8]);
      end
    end else begin
      d[0] = seg_encode(src[3:0]);
      d[1] = seg_encode(src[7:4]);
    end
    return d;
  endfunction

  state_t          state_r, state_s;
  logic [3:0]      cnt_r, cnt_s;
  logic [n-1:0]    bin_r, bin_s;
  logic [11:0]     bcd_r, bcd_s;
  logic [11:0]     adj_s;
  logic            mode_c_r, mode_c_s;
  logic [n-1:0]    src_r, src_s;
  logic [n-1:0]    last_value_r, last_value_s;
  logic            last_mode_r, last_mode_s;
  logic            dirty_r, dirty_s;
  logic [3:0][6:0] dig_r, dig_s;
  logic [RW-1:0]   refresh_r;
  logic [1:0]      idx_r;

  // Conversion FSM: next state and datapath, holding everything by default.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    bin_s        = bin_r;
    bcd_s        = bcd_r;
    adj_s        = bcd_adjust(bcd_r);
    mode_c_s     = mode_c_r;
    src_s        = src_r;
    last_value_s = last_value_r;
    last_mode_s  = last_mode_r;
    dirty_s      = dirty_r;
    dig_s        = dig_r;
    case (state_r)
      IDLE: begin
        if (dirty_r || (Value != last_value_r) || (Mode != last_mode_r)) begin
          // Work on private copies so later input changes cannot disturb us.
          bin_s    = Value;
          src_s    = Value;
          bcd_s    = 12'd0;
          mode_c_s = Mode;
          cnt_s    = 4'd0;
          state_s  = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        {bcd_s, bin_s} = {adj_s[10:0], bin_r, 1'b0};
        cnt_s          = cnt_r + 4'd1;
        if (cnt_r == 4'(n - 1)) begin
          state_s = COMMIT;
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT: begin
        // All four digits change together so no partial value is shown.
        dig_s        = build_digits(mode_c_r, src_r, bcd_r);
        last_value_s = src_r;
        last_mode_s  = mode_c_r;
        dirty_s      = 1'b0;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Conversion FSM state, datapath and Busy registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      bin_r        <= '0;
      bcd_r        <= 12'd0;
      mode_c_r     <= 1'b0;
      src_r        <= '0;
      last_value_r <= '0;
      last_mode_r  <= 1'b0;
      dirty_r      <= 1'b1;
      dig_r        <= {4{SEG_BLANK}};
      Busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bin_r        <= bin_s;
      bcd_r        <= bcd_s;
      mode_c_r     <= mode_c_s;
      src_r        <= src_s;
      last_value_r <= last_value_s;
      last_mode_r  <= last_mode_s;
      dirty_r      <= dirty_s;
      dig_r        <= dig_s;
      Busy         <= (state_s != IDLE);
    end
  end

  // Digit scan: free-running refresh counter, digit index and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      refresh_r <= '0;
      idx_r     <= 2'd0;
      An        <= 4'hF;
      Seg       <= SEG_BLANK;
    end else begin
      if (refresh_r == RW'(REFRESH - 1)) begin
        refresh_r <= '0;
        idx_r     <= idx_r + 2'd1;
      end else begin
        refresh_r <= refresh_r + RW'(1);
        idx_r     <= idx_r;
      end
      An  <= ~(4'b0001 << idx_r);
      Seg <= dig_r[idx_r];
    end
  end

endmodule

// File: tb/tb_led_seg_scan.sv
// Directed self-checking bench for led_seg_scan with REFRESH = 4.
module tb_led_seg_scan;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Value;
  logic       Mode;
  logic [6:0] Seg;
  logic [3:0] An;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_seg_scan #(.n(8), .REFRESH(4)) dut (
    .clk  (clk),
    .Reset(Reset),
    .Value(Value),
    .Mode (Mode),
    .Seg  (Seg),
    .An   (An),
    .Busy (Busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int an_to_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 4;
    endcase
  endfunction

  task automatic wait_an(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (An === pat) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (Busy === 1'b0) ok = 1'b1;
      else tick();
    end
    check_eq({tag, "_idle"}, 32'(ok), 32'd1);
    tick();
    tick();
  endtask

  task automatic check_display(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
    logic [6:0] exp [4];
    logic [3:0] pat;
    bit ok;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int d = 0; d < 4; d++) begin
      pat = 4'b0001 << d;
      pat = ~pat;
      wait_an(pat, ok);
      check_eq($sformatf("%s_an%0d_seen", tag, d), 32'(ok), 32'd1);
      check_eq($sformatf("%s_seg%0d", tag, d), 32'(Seg), 32'(exp[d]));
    end
  endtask

  task automatic count_busy(input string tag);
    int nb;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      if (Busy !== 1'b1) break;
      nb++;
      tick();
    end
    check_eq(tag, 32'(nb), 32'd9);
  endtask

  logic [6:0] old_d [4];
  logic [6:0] d100  [4];
  logic [6:0] d37   [4];

  initial begin
    bit ok;
    int bad;
    int seen100;
    int idx;
    int run;
    logic [3:0] pat;

    old_d[0] = 7'h78; old_d[1] = 7'h02; old_d[2] = 7'h79; old_d[3] = 7'h7F;
    d100[0]  = 7'h40; d100[1]  = 7'h40; d100[2]  = 7'h79; d100[3]  = 7'h7F;
    d37[0]   = 7'h78; d37[1]   = 7'h30; d37[2]   = 7'h7F; d37[3]   = 7'h7F;

    // Reset state.
    Reset = 1'b1; Value = 8'd0; Mode = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_an",   32'(An),   32'hF);
    check_eq("rst_seg",  32'(Seg),  32'h7F);

    // First cycle after reset: digit 0 enabled, still blank, conversion loaded.
    Reset = 1'b0;
    tick();
    check_eq("rel_an",   32'(An),   32'hE);
    check_eq("rel_seg",  32'(Seg),  32'h7F);
    check_eq("rel_busy", 32'(Busy), 32'd1);
    count_busy("rel_busy_len");
    wait_idle("dec0");
    check_display("dec0", 7'h40, 7'h7F, 7'h7F, 7'h7F);

    // Scan timing: each enable held exactly REFRESH cycles.
    wait_an(4'b0111, ok);
    check_eq("scan_sync3", 32'(ok), 32'd1);
    wait_an(4'b1110, ok);
    check_eq("scan_sync0", 32'(ok), 32'd1);
    for (int p = 0; p < 4; p++) begin
      pat = 4'b0001 << p;
      pat = ~pat;
      check_eq($sformatf("scan_pat%0d", p), 32'(An), 32'(pat));
      run = 0;
      while ((An === pat) && (run < 20)) begin
        run++;
        tick();
      end
      check_eq($sformatf("scan_len%0d", p), 32'(run), 32'd4);
    end
    check_eq("scan_wrap", 32'(An), 32'hE);

    // 255 decimal, Busy exactly 9 cycles.
    Value = 8'd255;
    tick();
    check_eq("busy_rise", 32'(Busy), 32'd1);
    count_busy("busy_len255");
    wait_idle("dec255");
    check_display("dec255", 7'h12, 7'h12, 7'h24, 7'h7F);

    // 0xA7 in hex, then decimal 167 after a Mode toggle.
    Value = 8'hA7; Mode = 1'b0;
    tick();
    wait_idle("hexa7");
    check_display("hexa7", 7'h78, 7'h08, 7'h7F, 7'h7F);
    Mode = 1'b1;
    tick();
    check_eq("mode_reconv", 32'(Busy), 32'd1);
    wait_idle("dec167");
    check_display("dec167", 7'h78, 7'h02, 7'h79, 7'h7F);

    // 100 then 37 three cycles after the load: no intermediate pattern.
    Value = 8'd100;
    tick();
    bad = 0;
    seen100 = 0;
    for (int off = 0; off <= 30; off++) begin
      idx = an_to_idx(An);
      if (idx == 4) begin
        bad++;
      end else if ((Seg !== old_d[idx]) && (Seg !== d100[idx]) && (Seg !== d37[idx])) begin
        bad++;
      end
      if ((idx < 2) && (Seg === d100[idx])) seen100 = 1;
      if (off == 8)  check_eq("chg_busy8",  32'(Busy), 32'd1);
      if (off == 9)  check_eq("chg_busy9",  32'(Busy), 32'd0);
      if (off == 10) check_eq("chg_busy10", 32'(Busy), 32'd1);
      if (off == 19) check_eq("chg_busy19", 32'(Busy), 32'd0);
      if (off == 3)  Value = 8'd37;
      tick();
    end
    check_eq("no_glitch", 32'(bad), 32'd0);
    check_eq("saw_100", 32'(seen100), 32'd1);
    check_display("dec37", 7'h78, 7'h30, 7'h7F, 7'h7F);

    // Reset in the middle of SHIFT (cnt = 4).
    Value = 8'd55;
    tick();
    repeat (4) tick();
    check_eq("pre_rst_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    check_eq("mid_rst_busy", 32'(Busy), 32'd0);
    check_eq("mid_rst_an",   32'(An),   32'hF);
    check_eq("mid_rst_seg",  32'(Seg),  32'h7F);
    Reset = 1'b0;
    tick();
    check_eq("post_rst_an",   32'(An),   32'hE);
    check_eq("post_rst_seg",  32'(Seg),  32'h7F);
    count_busy("post_rst_busy_len");
    wait_idle("dec55");
    check_display("dec55", 7'h12, 7'h12, 7'h7F, 7'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
